// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for a chunked multiplier: walks every (A-chunk, B-chunk)
// partial product high-to-low, steering the operand muxes, shifter and accumulator.
module mult_seq_ctrl #(
    parameter int CHUNKS = 2,
    parameter int SW     = (CHUNKS > 2) ? $clog2(CHUNKS) : 1,
    parameter int HW     = $clog2(2*CHUNKS-1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic [1:0]    state,
    output logic [SW-1:0] sel_a,
    output logic [SW-1:0] sel_b,
    output logic [HW-1:0] sel_shifter,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          busy,
    output logic          done_flag
);

    localparam int             STW  = 2*SW;
    localparam logic [STW-1:0] CH_W = STW'(CHUNKS);
    localparam logic [STW-1:0] LAST = STW'(CHUNKS*CHUNKS-1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CLEAR = 2'b01,
        S_ACCUM = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e         state_q, state_d;
    logic [STW-1:0] step_q, step_d;

    // Step is parked at zero outside ACCUM so it can never wrap or leak into the selects.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else begin
                    state_d = S_ACCUM;
                    step_d  = LAST;
                end
            end
            S_ACCUM: begin
                if (abort) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else if (step_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q - STW'(1);
                end
            end
            S_DONE: begin
                step_d = '0;
                if (abort || !start) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Moore decode: everything below depends only on state_q and step_q.
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        busy      = 1'b0;
        done_flag = 1'b0;
        case (state_q)
            S_CLEAR: begin
                acc_clr = 1'b1;
                busy    = 1'b1;
            end
            S_ACCUM: begin
                acc_en = 1'b1;
                busy   = 1'b1;
                sel_a  = SW'(step_q / CH_W);
                sel_b  = SW'(step_q % CH_W);
            end
            S_DONE: begin
                done_flag = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign sel_shifter = HW'(sel_a) + HW'(sel_b);
    assign state       = state_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: one CHUNKS=2 instance (A) and one CHUNKS=4 instance (B).
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [1:0] state_a, state_b;
    logic       sa_a, sb_a;
    logic [1:0] sh_a, sa_b, sb_b;
    logic [2:0] sh_b;
    logic       clr_a, en_a, busy_a, done_a, clr_b, en_b, busy_b, done_b;

    mult_seq_ctrl #(.CHUNKS(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .state(state_a),
        .sel_a(sa_a), .sel_b(sb_a), .sel_shifter(sh_a), .acc_clr(clr_a),
        .acc_en(en_a), .busy(busy_a), .done_flag(done_a)
    );

    mult_seq_ctrl #(.CHUNKS(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .state(state_b),
        .sel_a(sa_b), .sel_b(sb_b), .sel_shifter(sh_b), .acc_clr(clr_b),
        .acc_en(en_b), .busy(busy_b), .done_flag(done_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          dut;
        logic [12:0] vec;
        string       name;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] IDLE = 2'b00, CLEAR = 2'b01, ACCUM = 2'b10, DONE = 2'b11;

    // {state, sel_a, sel_b, sel_shifter, acc_clr, acc_en, busy, done_flag}
    function automatic logic [12:0] mk(input logic [1:0] st, input int a, input int b, input int sh);
        return {st, 2'(a), 2'(b), 3'(sh), st == CLEAR, st == ACCUM,
                (st == CLEAR) || (st == ACCUM), st == DONE};
    endfunction

    function automatic logic [12:0] obs(input int dut);
        if (dut == 0)
            return {state_a, 1'b0, sa_a, 1'b0, sb_a, 1'b0, sh_a, clr_a, en_a, busy_a, done_a};
        else
            return {state_b, sa_b, sb_b, sh_b, clr_b, en_b, busy_b, done_b};
    endfunction

    task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input int d, input logic [1:0] st,
                        input int a, input int b, input int sh, input string nm);
        exp_t e;
        e.cyc = c; e.dut = d; e.vec = mk(st, a, b, sh); e.name = nm;
        q.push_back(e);
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every expectation due at the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: expectation for cyc %0d missed at cyc %0d", e.name, e.cyc, cyc);
                end else begin
                    check(e.name, obs(e.dut), e.vec);
                end
            end
        end
    end

    // CHUNKS=2 single start; optional start toggling while ACCUM runs.
    task automatic run_pulse_a(input string tag, input bit toggle);
        int c;
        int ta[4] = '{1, 1, 0, 0};
        int tb[4] = '{1, 0, 1, 0};
        int ts[4] = '{2, 1, 1, 0};
        c = cyc;
        start_a = 1'b1;
        push(c+1, 0, CLEAR, 0, 0, 0, {tag, "_clear"});
        for (int k = 0; k < 4; k++)
            push(c+2+k, 0, ACCUM, ta[k], tb[k], ts[k], {tag, "_accum"});
        push(c+6, 0, DONE, 0, 0, 0, {tag, "_done"});
        push(c+7, 0, IDLE, 0, 0, 0, {tag, "_idle"});
        step_cycle();
        start_a = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            step_cycle();
            start_a = toggle && (k == 3 || k == 5);
        end
        start_a = 1'b0;
    endtask

    // CHUNKS=4: start held high until cycle c+hold, so DONE persists until then.
    task automatic run_held_b(input string tag, input int hold);
        int c;
        c = cyc;
        start_b = 1'b1;
        push(c+1, 1, CLEAR, 0, 0, 0, {tag, "_clear"});
        for (int k = 0; k < 16; k++)
            push(c+2+k, 1, ACCUM, (15-k)/4, (15-k)%4, (15-k)/4 + (15-k)%4, {tag, "_accum"});
        for (int k = 18; k <= hold; k++)
            push(c+k, 1, DONE, 0, 0, 0, {tag, "_done"});
        push(c+hold+1, 1, IDLE, 0, 0, 0, {tag, "_idle"});
        repeat (hold) step_cycle();
        start_b = 1'b0;
        repeat (3) step_cycle();
    endtask

    initial begin
        int c;
        #3;
        check("reset_a", obs(0), 13'd0);
        check("reset_b", obs(1), 13'd0);
        repeat (2) step_cycle();
        rst = 1'b1;
        push(cyc+1, 0, IDLE, 0, 0, 0, "post_rst_a");
        push(cyc+1, 1, IDLE, 0, 0, 0, "post_rst_b");
        step_cycle();

        run_pulse_a("pulse", 1'b0);
        run_held_b("held", 20);

        // Abort on the second ACCUM cycle.
        c = cyc;
        start_a = 1'b1;
        push(c+1, 0, CLEAR, 0, 0, 0, "abort_clear");
        push(c+2, 0, ACCUM, 1, 1, 2, "abort_accum0");
        push(c+3, 0, ACCUM, 1, 0, 1, "abort_accum1");
        for (int k = 4; k <= 7; k++) push(c+k, 0, IDLE, 0, 0, 0, "abort_idle");
        step_cycle();
        start_a = 1'b0;
        step_cycle();
        step_cycle();
        abort_a = 1'b1;
        step_cycle();
        abort_a = 1'b0;
        repeat (4) step_cycle();
        run_pulse_a("restart", 1'b0);

        // start and abort together in IDLE.
        c = cyc;
        start_a = 1'b1;
        abort_a = 1'b1;
        push(c+1, 0, IDLE, 0, 0, 0, "start_abort_idle");
        push(c+2, 0, IDLE, 0, 0, 0, "start_abort_idle");
        step_cycle();
        step_cycle();
        start_a = 1'b0;
        abort_a = 1'b0;
        step_cycle();

        // Asynchronous reset during the second ACCUM cycle of B.
        c = cyc;
        start_b = 1'b1;
        push(c+1, 1, CLEAR, 0, 0, 0, "rst_mid_clear");
        push(c+2, 1, ACCUM, 3, 3, 6, "rst_mid_accum");
        step_cycle();
        start_b = 1'b0;
        step_cycle();
        step_cycle();
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_b", obs(1), 13'd0);
        check("async_rst_a", obs(0), 13'd0);
        step_cycle();
        rst = 1'b1;
        push(cyc+1, 1, IDLE, 0, 0, 0, "rst_release_idle");
        push(cyc+2, 1, IDLE, 0, 0, 0, "rst_release_idle");
        step_cycle();
        step_cycle();
        run_held_b("after_rst", 18);

        run_pulse_a("toggle", 1'b1);

        for (int i = 0; i < 100 && q.size() > 0; i++) step_cycle();
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameter CHUNKS, default 2: operand chunks per operand (>=2); one operation has CHUNKS*CHUNKS partial products.
REQ-002 Parameter SW = clog2(CHUNKS) (min 1), default 1: width of chunk-select outputs.
REQ-003 Parameter HW = clog2(2*CHUNKS-1) (min 1), default 2: width of shift-amount output, in chunk units.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  operation request, level; sampled only in IDLE and DONE.
REQ-007 abort  input  1  cancels the operation in progress.
REQ-008 state  output  2  current state: IDLE=00, CLEAR=01, ACCUM=10, DONE=11.
REQ-009 sel_a  output  SW  chunk index of operand A for the current partial product.
REQ-010 sel_b  output  SW  chunk index of operand B for the current partial product.
REQ-011 sel_shifter  output  HW  partial-product left shift, in chunks; always equals sel_a+sel_b.
REQ-012 acc_clr  output  1  clear the datapath accumulator.
REQ-013 acc_en  output  1  add the shifted partial product to the accumulator.
REQ-014 busy  output  1  high in CLEAR and ACCUM.
REQ-015 done_flag  output  1  high in DONE only.

Function
REQ-016 The block SHALL be a Moore FSM; all outputs SHALL be decoded from registered state and the registered step counter only.
REQ-017 The step counter SHALL be (2*SW) bits wide, with sel_a = step / CHUNKS and sel_b = step mod CHUNKS.
REQ-018 IDLE: if start=1 and abort=0, the next state SHALL be CLEAR; otherwise the FSM SHALL stay in IDLE.
REQ-019 CLEAR (1 cycle): acc_clr=1 and step is loaded with CHUNKS*CHUNKS-1; the next state SHALL be ACCUM.
REQ-020 ACCUM: acc_en=1; step SHALL decrement by 1 per cycle; when step=0 the next state SHALL be DONE.
REQ-021 ACCUM SHALL last exactly CHUNKS*CHUNKS cycles, in step order high-to-low. For CHUNKS=2 the (sel_a,sel_b,sel_shifter) sequence SHALL be (1,1,2), (1,0,1), (0,1,1), (0,0,0).
REQ-022 DONE: done_flag=1 for at least one cycle. If start=0 the next state SHALL be IDLE; if start=1 the FSM SHALL hold DONE (no automatic retrigger).
REQ-023 Latency: with start first sampled high in IDLE at edge t, the block SHALL be in CLEAR after t, in ACCUM after t+1, and in DONE after t+1+CHUNKS*CHUNKS.
REQ-024 Once CLEAR is entered, deasserting start SHALL NOT affect the operation.
REQ-025 abort=1 at any edge in CLEAR, ACCUM or DONE SHALL force IDLE on that edge. done_flag SHALL NOT assert for an aborted operation.
REQ-026 abort SHALL take priority over start.
REQ-027 In IDLE and DONE: sel_a=0, sel_b=0, sel_shifter=0, acc_en=0, acc_clr=0. No output SHALL ever be X.
REQ-028 In CLEAR: sel_a, sel_b and sel_shifter SHALL be 0.
REQ-029 Unreachable encodings do not exist for the 2-bit state; the step counter SHALL NOT wrap (it is loaded only in CLEAR).

Reset
REQ-030 rst=0 SHALL, asynchronously and immediately, set state=IDLE, step=0, busy=0, done_flag=0, acc_en=0, acc_clr=0, and sel_a/sel_b/sel_shifter=0.
REQ-031 Reset asserted mid-operation SHALL discard the operation; after release the FSM SHALL wait in IDLE for start.
REQ-032 Release of rst SHALL be synchronous-safe: the first transition occurs on the first rising clk edge after release.

Verification
REQ-033 Bench scenarios:
- CHUNKS=2, start pulse for 1 cycle -> CLEAR 1 cycle (acc_clr=1); ACCUM 4 cycles with (1,1,2),(1,0,1),(0,1,1),(0,0,0); done_flag on the 6th cycle after the start edge; then IDLE.
- CHUNKS=4, start held high throughout -> 16 ACCUM cycles, step 15..0, sel_shifter=sel_a+sel_b on every cycle, max value 6; FSM holds DONE until start=0, then returns to IDLE.
- abort=1 on the 2nd ACCUM cycle -> IDLE on the next edge; done_flag never asserts; a new start then runs a full clean sequence.
- start=1 and abort=1 together in IDLE -> FSM stays in IDLE, all outputs 0.
- rst=0 asynchronously in the middle of ACCUM -> all outputs 0 without waiting for a clock edge; after release, start gives the normal latency.
- start toggled during ACCUM -> sequence and done timing identical to the single-pulse case.
